// File: rtl/esn7e_st_pkt.sv
// ESN source word FIFO feeding an Avalon-ST packetizer (PKT_LEN words per packet),
// with sticky overflow flag and saturating drop counter for words lost while full.
module esn7e_st_pkt #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PKT_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    input  logic        clr_stat,
    output logic        overflow,
    output logic [15:0] drop_count
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(PKT_LEN);
    localparam int unsigned SW = 16;

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          valid_q, valid_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          ovf_q, ovf_d;
    logic [SW-1:0] drop_q, drop_d;

    logic full;
    logic rd_en;
    logic wr_en;
    logic drop;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a word on a transfer.
    assign full  = (count_q == CW'(DEPTH));
    assign rd_en = valid_q & out_ready;
    assign wr_en = in_valid & (~full | rd_en);
    assign drop  = in_valid & full & ~rd_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            beat_d   = (beat_q == BW'(PKT_LEN - 1)) ? '0 : beat_q + BW'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A drop in the clear cycle wins: the stats restart at one.
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_stat) begin
                drop_d = SW'(1);
            end else if (drop_q != {SW{1'b1}}) begin
                drop_d = drop_q + SW'(1);
            end
        end else if (clr_stat) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end

        valid_d = (count_d != '0);
        sop_d   = valid_d & (beat_d == '0);
        eop_d   = valid_d & (beat_d == BW'(PKT_LEN - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            valid_q  <= valid_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage carries no reset; contents are only observed once occupancy covers them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = mem_q[rd_ptr_q];
    assign out_sop    = sop_q;
    assign out_eop    = eop_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_esn7e_st_pkt.sv
// Directed testbench for esn7e_st_pkt (DEPTH=16, PKT_LEN=64).
module tb_esn7e_st_pkt;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        clr_stat;
    logic        overflow;
    logic [15:0] drop_count;

    int checks;
    int errors;

    esn7e_st_pkt #(.DEPTH(16), .PKT_LEN(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .clr_stat   (clr_stat),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic apply_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_stat  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1; clr_stat = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (out_sop !== 1'b0) begin errors++; $display("FAIL reset_sop: got %0b expected 0", out_sop); end
        checks++; if (out_eop !== 1'b0) begin errors++; $display("FAIL reset_eop: got %0b expected 0", out_eop); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %0b expected 0", out_valid); end
    endtask

    task automatic test_basic_flow();
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c <= 130; c++) begin
            if (c == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %0b expected 0", out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid w%0d: got %0b expected 1", c - 1, out_valid); end
                checks++; if (out_data !== 32'(c - 1)) begin errors++; $display("FAIL basic_data: got %0d expected %0d", out_data, c - 1); end
                checks++; if (out_sop !== (((c - 1) % 64) == 0)) begin errors++; $display("FAIL basic_sop w%0d: got %0b expected %0b", c - 1, out_sop, (((c - 1) % 64) == 0)); end
                checks++; if (out_eop !== (((c - 1) % 64) == 63)) begin errors++; $display("FAIL basic_eop w%0d: got %0b expected %0b", c - 1, out_eop, (((c - 1) % 64) == 63)); end
            end
            in_valid = (c < 130);
            in_data  = 32'(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained_valid: got %0b expected 0", out_valid); end
    endtask

    task automatic test_overflow();
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drop_count: got %0d expected 4", drop_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid w%0d: got %0b expected 1", i, out_valid); end
            checks++; if (out_data !== 32'(i)) begin errors++; $display("FAIL ovf_data: got %0d expected %0d", out_data, i); end
            checks++; if (out_sop !== (i == 0)) begin errors++; $display("FAIL ovf_sop w%0d: got %0b expected %0b", i, out_sop, (i == 0)); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid: got %0b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_simultaneous();
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(100 + i);
            @(negedge clk);
        end
        for (int j = 0; j < 10; j++) begin
            checks++; if (out_data !== 32'(100 + j)) begin errors++; $display("FAIL full_rw_data: got %0d expected %0d", out_data, 100 + j); end
            checks++; if (out_sop !== (j == 0)) begin errors++; $display("FAIL full_rw_sop j%0d: got %0b expected %0b", j, out_sop, (j == 0)); end
            in_valid  = 1'b1;
            in_data   = 32'(116 + j);
            out_ready = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL full_rw_no_drop: got %0d expected 0", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_rw_no_ovf: got %0b expected 0", overflow); end
        // still full: one more word with no read must be dropped
        in_valid = 1'b1; in_data = 32'd7777;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL full_rw_still_full: got %0d expected 1", drop_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_rw_drain_valid i%0d: got %0b expected 1", i, out_valid); end
            checks++; if (out_data !== 32'(110 + i)) begin errors++; $display("FAIL full_rw_drain_data: got %0d expected %0d", out_data, 110 + i); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_rw_empty: got %0b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int   exp_idx;
        int   w;
        int   sop_n;
        int   eop_n;
        int   stall_n;
        logic stalled;
        logic [31:0] pd;
        logic ps;
        logic pe;
        apply_reset();
        exp_idx = 0; w = 0; sop_n = 0; eop_n = 0; stall_n = 0; stalled = 1'b0;
        pd = '0; ps = 1'b0; pe = 1'b0;
        for (int c = 0; c < 400 && exp_idx < 64; c++) begin
            if (stalled) begin
                checks++; if (out_data !== pd) begin errors++; $display("FAIL bp_hold_data: got %0h expected %0h", out_data, pd); end
                checks++; if (out_sop !== ps || out_eop !== pe) begin errors++; $display("FAIL bp_hold_flags: got sop%0b eop%0b expected sop%0b eop%0b", out_sop, out_eop, ps, pe); end
            end
            if (out_valid) begin
                checks++; if (out_data !== 32'h1000 + 32'(exp_idx)) begin errors++; $display("FAIL bp_data: got %0h expected %0h", out_data, 32'h1000 + 32'(exp_idx)); end
                checks++; if (out_sop !== (exp_idx == 0) || out_eop !== (exp_idx == 63)) begin errors++; $display("FAIL bp_flags w%0d: got sop%0b eop%0b", exp_idx, out_sop, out_eop); end
            end
            out_ready = (c % 2 == 0);
            in_valid  = (c % 2 == 0) && (w < 64);
            in_data   = 32'h1000 + 32'(w);
            if (in_valid) w++;
            stalled = out_valid && !out_ready;
            if (stalled) stall_n++;
            pd = out_data; ps = out_sop; pe = out_eop;
            if (out_valid && out_ready) begin
                if (out_sop) sop_n++;
                if (out_eop) eop_n++;
                exp_idx++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (exp_idx !== 64) begin errors++; $display("FAIL bp_timeout: got %0d words expected 64", exp_idx); end
        checks++; if (sop_n !== 1) begin errors++; $display("FAIL bp_sop_count: got %0d expected 1", sop_n); end
        checks++; if (eop_n !== 1) begin errors++; $display("FAIL bp_eop_count: got %0d expected 1", eop_n); end
        checks++; if (stall_n < 32) begin errors++; $display("FAIL bp_stalls: got %0d expected at least 32", stall_n); end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        for (int c = 0; c < 35; c++) begin
            in_valid  = 1'b1;
            in_data   = 32'(c);
            out_ready = (c >= 1 && c <= 30);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd30) begin errors++; $display("FAIL mid_head: got v%0b d%0d expected v1 d30", out_valid, out_data); end
        checks++; if (out_sop !== 1'b0) begin errors++; $display("FAIL mid_sop_before: got %0b expected 0", out_sop); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %0b expected 0", out_valid); end
        checks++; if (out_sop !== 1'b0 || out_eop !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got sop%0b eop%0b expected 0 0", out_sop, out_eop); end
        in_valid = 1'b1; in_data = 32'd999;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discarded: got %0b expected 0", out_valid); end
        in_valid = 1'b1; in_data = 32'd500;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'd500) begin errors++; $display("FAIL mid_first_word: got v%0b d%0d expected v1 d500", out_valid, out_data); end
        checks++; if (out_sop !== 1'b1) begin errors++; $display("FAIL mid_first_sop: got %0b expected 1", out_sop); end
    endtask

    task automatic test_stats();
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            @(negedge clk);
        end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL stat_fill_no_drop: got %0d expected 0", drop_count); end
        for (int i = 0; i < 70000; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(1000 + i);
            @(negedge clk);
            if (i == 65533) begin
                checks++; if (drop_count !== 16'd65534) begin errors++; $display("FAIL stat_pre_sat: got %0d expected 65534", drop_count); end
            end
        end
        in_valid = 1'b0;
        checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL stat_saturated: got %0h expected ffff", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stat_sat_ovf: got %0b expected 1", overflow); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL stat_head_kept: got %0d expected 0", out_data); end
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL stat_clear_count: got %0d expected 0", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stat_clear_ovf: got %0b expected 0", overflow); end
        clr_stat = 1'b1; in_valid = 1'b1; in_data = 32'd42;
        @(negedge clk);
        clr_stat = 1'b0; in_valid = 1'b0;
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL stat_clear_drop_count: got %0d expected 1", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stat_clear_drop_ovf: got %0b expected 1", overflow); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_stat  = 1'b0;
        test_reset();
        test_basic_flow();
        test_overflow();
        test_full_simultaneous();
        test_backpressure();
        test_reset_mid_packet();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
